hook_controller: RTL and testbench

- Sequences the miner's hook through swing, drop and drag phases, one step per frame tick.
- Publishes hook angle and length to the hook renderer and collision logic.
- Raises a redraw request to the view FSM whenever the hook moves, and consumes the collision detector's hit and weight result.
- Sits between the input/collision logic and the game view FSM, and replaces per-angle states with an arithmetic angle register.

---
 rtl/hook_controller.sv | 182 ++++++++++++++++++
 tb/tb_hook_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hook_controller.sv
// Miner hook sequencer: swing, drop and drag phases, one step per frame.
// Publishes angle/length and raises redraw_req on every visible change.
module hook_controller #(
  parameter int ANGLE_MIN  = 30,
  parameter int ANGLE_MAX  = 150,
  parameter int ANGLE_STEP = 10,
  parameter int ANGLE_HOME = 90,
  parameter int LEN_MIN    = 8,
  parameter int LEN_MAX    = 200,
  parameter int DROP_STEP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame,
  input  logic       drop,
  input  logic       game_end,
  input  logic       hit,
  input  logic [1:0] hit_weight,
  input  logic       redraw_ack,
  output logic [7:0] degree,
  output logic [7:0] length,
  output logic       clockwise,
  output logic [2:0] phase,
  output logic       grabbed,
  output logic       grab_done,
  output logic [1:0] grab_weight,
  output logic       redraw_req
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SWING = 3'd1,
    DROP  = 3'd2,
    DRAG  = 3'd3,
    DONE  = 3'd4
  } phase_t;

  localparam logic [7:0] AMIN  = 8'(ANGLE_MIN);
  localparam logic [7:0] AMAX  = 8'(ANGLE_MAX);
  localparam logic [7:0] ASTEP = 8'(ANGLE_STEP);
  localparam logic [7:0] AHOME = 8'(ANGLE_HOME);
  localparam logic [7:0] LMIN  = 8'(LEN_MIN);
  localparam logic [7:0] LMAX  = 8'(LEN_MAX);
  localparam logic [7:0] DSTEP = 8'(DROP_STEP);

  phase_t     st;
  logic       drop_q;
  logic       drop_rise;
  logic [7:0] drag_step;
  logic [8:0] len_up;
  logic [8:0] len_floor;
  logic [7:0] len_inc;
  logic [7:0] len_dec;

  assign phase     = st;
  assign drop_rise = drop & ~drop_q;

  // Heavier loads reel in more slowly.
  always_comb begin
    drag_step = DSTEP;
    if (grabbed) begin
      if (grab_weight == 2'd0)      drag_step = 8'd4;
      else if (grab_weight == 2'd1) drag_step = 8'd2;
      else                          drag_step = 8'd1;
    end
  end

  assign len_up    = {1'b0, length} + {1'b0, DSTEP};
  assign len_inc   = (len_up > {1'b0, LMAX}) ? LMAX : len_up[7:0];
  assign len_floor = {1'b0, LMIN} + {1'b0, drag_step};
  assign len_dec   = ({1'b0, length} <= len_floor) ? LMIN
                   : length - drag_step;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      degree      <= AHOME;
      length      <= LMIN;
      clockwise   <= 1'b1;
      grabbed     <= 1'b0;
      grab_done   <= 1'b0;
      grab_weight <= 2'd0;
      redraw_req  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      drop_q    <= drop;
      grab_done <= 1'b0;
      // Any branch below that moves the hook re-asserts the request.
      if (redraw_ack) redraw_req <= 1'b0;
      case (st)
        IDLE: begin
          degree    <= AHOME;
          length    <= LMIN;
          clockwise <= 1'b1;
          if (enable) begin
            st         <= SWING;
            redraw_req <= 1'b1;
          end
        end
        DONE: begin
          if (!enable) begin
            st         <= IDLE;
            degree     <= AHOME;
            length     <= LMIN;
            clockwise  <= 1'b1;
            grabbed    <= 1'b0;
            redraw_req <= 1'b1;
          end
        end
        SWING, DROP, DRAG: begin
          if (game_end) begin
            st         <= DONE;
            grabbed    <= 1'b0;
            redraw_req <= 1'b1;
          end else if (!enable) begin
            st         <= IDLE;
            degree     <= AHOME;
            length     <= LMIN;
            clockwise  <= 1'b1;
            grabbed    <= 1'b0;
            redraw_req <= 1'b1;
          end else begin
            case (st)
              SWING: begin
                if (drop_rise) begin
                  st         <= DROP;
                  redraw_req <= 1'b1;
                end else if (frame) begin
                  redraw_req <= 1'b1;
                  if (clockwise && degree == AMAX) begin
                    clockwise <= 1'b0;
                    degree    <= AMAX - ASTEP;
                  end else if (!clockwise && degree == AMIN) begin
                    clockwise <= 1'b1;
                    degree    <= AMIN + ASTEP;
                  end else if (clockwise) begin
                    degree <= degree + ASTEP;
                  end else begin
                    degree <= degree - ASTEP;
                  end
                end
              end
              DROP: begin
                if (hit) begin
                  st          <= DRAG;
                  grabbed     <= 1'b1;
                  grab_weight <= hit_weight;
                  redraw_req  <= 1'b1;
                end else if (length == LMAX) begin
                  st         <= DRAG;
                  grabbed    <= 1'b0;
                  redraw_req <= 1'b1;
                end else if (frame) begin
                  length     <= len_inc;
                  redraw_req <= 1'b1;
                end
              end
              DRAG: begin
                if (length == LMIN) begin
                  st         <= SWING;
                  grab_done  <= grabbed;
                  grabbed    <= 1'b0;
                  redraw_req <= 1'b1;
                end else if (frame) begin
                  length     <= len_dec;
                  redraw_req <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        default: begin
          st         <= IDLE;
          redraw_req <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hook_controller.sv
// Bench for hook_controller: directed vectors, literal checks and a
// per-cycle comparison against a triangle-wave/arithmetic hook model.
module tb_hook_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, frame, drop, game_end, hit, redraw_ack;
  logic [1:0] hit_weight;
  logic [7:0] degree, length;
  logic       clockwise, grabbed, grab_done, redraw_req;
  logic [2:0] phase;
  logic [1:0] grab_weight;

  int total = 0;
  int bad   = 0;

  hook_controller dut (
    .clk(clk), .reset(reset), .enable(enable), .frame(frame),
    .drop(drop), .game_end(game_end), .hit(hit),
    .hit_weight(hit_weight), .redraw_ack(redraw_ack),
    .degree(degree), .length(length), .clockwise(clockwise),
    .phase(phase), .grabbed(grabbed), .grab_done(grab_done),
    .grab_weight(grab_weight), .redraw_req(redraw_req)
  );

  always #5 clk = ~clk;

  // Model: swing angle is a position on a 24-step triangle wave.
  localparam int N = 12;
  int wstep [4] = '{4, 2, 1, 1};
  int m_ph = 0, m_pos = 6, m_len = 8, m_w = 0;
  bit m_grab = 0, m_done = 0, m_req = 0, m_dq = 0;

  function automatic int deg_of(input int p);
    if (p == 0) return 30;
    if (p <= N) return 30 + 10 * p;
    return 150 - 10 * (p - N);
  endfunction

  function automatic bit cw_of(input int p);
    return (p >= 1 && p <= N);
  endfunction

  task automatic m_reset();
    m_ph = 0; m_pos = 6; m_len = 8; m_w = 0;
    m_grab = 0; m_done = 0; m_req = 0; m_dq = 0;
  endtask

  task automatic m_idle();
    m_ph = 0; m_pos = 6; m_len = 8; m_grab = 0;
  endtask

  task automatic m_step();
    int od, ol, op, s;
    bit rise;
    od = deg_of(m_pos); ol = m_len; op = m_ph;
    rise = drop && !m_dq;
    m_dq = drop;
    m_done = 0;
    if (m_ph == 0) begin
      if (enable) m_ph = 1;
    end else if (m_ph == 4) begin
      if (!enable) m_idle();
    end else if (game_end) begin
      m_ph = 4; m_grab = 0;
    end else if (!enable) begin
      m_idle();
    end else if (m_ph == 1) begin
      if (rise) m_ph = 2;
      else if (frame) m_pos = (m_pos + 1) % (2 * N);
    end else if (m_ph == 2) begin
      if (hit) begin
        m_ph = 3; m_grab = 1; m_w = int'(hit_weight);
      end else if (m_len == 200) begin
        m_ph = 3; m_grab = 0;
      end else if (frame) begin
        m_len = (m_len + 4 > 200) ? 200 : m_len + 4;
      end
    end else begin
      if (m_len == 8) begin
        m_ph = 1; m_done = m_grab; m_grab = 0;
      end else if (frame) begin
        s = m_grab ? wstep[m_w] : 4;
        m_len = (m_len - s < 8) ? 8 : m_len - s;
      end
    end
    m_req = (deg_of(m_pos) != od || m_len != ol || m_ph != op)
         || (m_req && !redraw_ack);
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_reset();
    else m_step();
  end

  logic [24:0] got, want;

  always @(negedge clk) begin
    got  = {degree, length, clockwise, phase,
            grabbed, grab_done, grab_weight, redraw_req};
    want = {8'(deg_of(m_pos)), 8'(m_len), cw_of(m_pos), 3'(m_ph),
            m_grab, m_done, 2'(m_w), m_req};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL cycle t=%0t got=%h want=%h", $time, got, want);
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frm();
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  int exp_deg [7] = '{100, 110, 120, 130, 140, 150, 140};
  int exp_cw  [7] = '{1, 1, 1, 1, 1, 1, 0};

  initial begin
    reset = 1'b1; enable = 1'b0; frame = 1'b0; drop = 1'b0;
    game_end = 1'b0; hit = 1'b0; hit_weight = 2'd0; redraw_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_phase", 32'(phase), 0);
    chk("rst_degree", 32'(degree), 90);
    chk("rst_length", 32'(length), 8);
    chk("rst_cw", 32'(clockwise), 1);
    chk("rst_grabbed", 32'(grabbed), 0);
    chk("rst_done", 32'(grab_done), 0);
    chk("rst_weight", 32'(grab_weight), 0);
    chk("rst_req", 32'(redraw_req), 0);

    // 1: swing up and turn around at 150
    enable = 1'b1; step();
    chk("enable_phase", 32'(phase), 1);
    chk("enable_req", 32'(redraw_req), 1);
    redraw_ack = 1'b1; step(); redraw_ack = 1'b0;
    chk("ack_clears", 32'(redraw_req), 0);
    for (int i = 0; i < 7; i++) begin
      frm();
      chk("swing_deg", 32'(degree), 32'(exp_deg[i]));
      chk("swing_cw", 32'(clockwise), 32'(exp_cw[i]));
      chk("swing_req", 32'(redraw_req), 1);
      redraw_ack = 1'b1; step(); redraw_ack = 1'b0;
      chk("swing_ack", 32'(redraw_req), 0);
    end

    // 2: ack racing a move keeps the request; bounce at 30
    frame = 1'b1; redraw_ack = 1'b1; step();
    frame = 1'b0; redraw_ack = 1'b0;
    chk("ack_vs_move_deg", 32'(degree), 130);
    chk("ack_vs_move_req", 32'(redraw_req), 1);
    repeat (10) frm();
    chk("bottom_deg", 32'(degree), 30);
    chk("bottom_cw", 32'(clockwise), 0);
    frm();
    chk("bounce_deg", 32'(degree), 40);
    chk("bounce_cw", 32'(clockwise), 1);

    // 3: drop without a hit, saturate, empty drag back
    repeat (8) frm();
    chk("pre_drop_deg", 32'(degree), 120);
    drop = 1'b1; frame = 1'b1; step(); frame = 1'b0;
    chk("drop_phase", 32'(phase), 2);
    chk("drop_no_step", 32'(degree), 120);
    repeat (5) frm();
    chk("drop_len28", 32'(length), 28);
    chk("drop_frozen", 32'(degree), 120);
    repeat (43) frm();
    chk("drop_len200", 32'(length), 200);
    chk("drop_still", 32'(phase), 2);
    step();
    chk("empty_drag", 32'(phase), 3);
    chk("empty_grab", 32'(grabbed), 0);
    repeat (48) frm();
    chk("drag_len8", 32'(length), 8);
    step();
    chk("back_swing", 32'(phase), 1);
    chk("empty_no_done", 32'(grab_done), 0);
    chk("resume_deg", 32'(degree), 120);
    chk("resume_cw", 32'(clockwise), 1);
    step();
    chk("no_retrigger", 32'(phase), 1);
    drop = 1'b0; step();

    // 4: hit with frame at 40, heavy load
    drop = 1'b1; step(); drop = 1'b0;
    chk("drop2_phase", 32'(phase), 2);
    repeat (8) frm();
    chk("drop2_len40", 32'(length), 40);
    hit = 1'b1; hit_weight = 2'd2; frame = 1'b1; step();
    hit = 1'b0; frame = 1'b0;
    chk("hit_phase", 32'(phase), 3);
    chk("hit_len", 32'(length), 40);
    chk("hit_grab", 32'(grabbed), 1);
    chk("hit_weight", 32'(grab_weight), 2);
    hit = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      frm();
      chk("heavy_len", 32'(length), 32'(40 - i));
    end
    hit = 1'b0;
    step();
    chk("done_pulse", 32'(grab_done), 1);
    chk("done_phase", 32'(phase), 1);
    chk("done_grab", 32'(grabbed), 0);
    chk("done_weight", 32'(grab_weight), 2);
    step();
    chk("done_once", 32'(grab_done), 0);

    // 5: game_end mid-drag, then back to idle
    drop = 1'b1; step(); drop = 1'b0;
    repeat (5) frm();
    chk("drop3_len", 32'(length), 28);
    hit = 1'b1; hit_weight = 2'd1; step(); hit = 1'b0;
    chk("hit3_grab", 32'(grabbed), 1);
    frm();
    chk("medium_len", 32'(length), 26);
    game_end = 1'b1; frame = 1'b1; step();
    game_end = 1'b0; frame = 1'b0;
    chk("end_phase", 32'(phase), 4);
    chk("end_len", 32'(length), 26);
    chk("end_grab", 32'(grabbed), 0);
    chk("end_no_done", 32'(grab_done), 0);
    frm();
    chk("done_hold_len", 32'(length), 26);
    chk("done_hold_deg", 32'(degree), 120);
    enable = 1'b0; step();
    chk("idle_phase", 32'(phase), 0);
    chk("idle_deg", 32'(degree), 90);
    chk("idle_len", 32'(length), 8);
    chk("idle_cw", 32'(clockwise), 1);

    // 6: asynchronous reset in the middle of a drop
    enable = 1'b1; step();
    drop = 1'b1; step(); drop = 1'b0;
    chk("drop4_phase", 32'(phase), 2);
    repeat (2) frm();
    chk("drop4_len", 32'(length), 16);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_phase", 32'(phase), 0);
    chk("async_len", 32'(length), 8);
    chk("async_deg", 32'(degree), 90);
    chk("async_req", 32'(redraw_req), 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post_rst_swing", 32'(phase), 1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
